// File: rtl/idelay_cal_pkg.sv
// Shared types and constants for the IDELAY tap calibration sequencer.
// Holds the controller state encoding, counter widths and the tap-width helper.
package idelay_cal_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_DLY,
    SETTLE,
    SAMPLE,
    STEP,
    EVAL,
    MOVE,
    MOVE_SETTLE,
    FAIL_RST,
    DONE_S,
    FAIL_S
  } cal_state_t;

  localparam int unsigned SETTLE_CNT_W = 8;
  localparam int unsigned SAMPLE_CNT_W = 8;

  function automatic int unsigned tap_width(input int unsigned num_taps);
    return $clog2(num_taps + 1);
  endfunction

endpackage

// File: rtl/idelay_window_tracker.sv
// Tracks runs of good taps during the sweep and reports the longest one and its centre.
// Outputs already account for a still-open run, so they are usable in the same cycle as close.
module idelay_window_tracker
  import idelay_cal_pkg::*;
#(
  parameter int unsigned TAP_W = tap_width(8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tap_valid,
  input  logic             tap_good,
  input  logic [TAP_W-1:0] tap_idx,
  input  logic             close,
  output logic [TAP_W-1:0] best_start,
  output logic [TAP_W-1:0] best_len,
  output logic [TAP_W-1:0] center
);

  logic [TAP_W-1:0] r_cur_start;
  logic [TAP_W-1:0] r_cur_len;
  logic [TAP_W-1:0] r_best_start;
  logic [TAP_W-1:0] r_best_len;
  logic             w_cur_wins;

  // Strictly longer only: on a tie the earlier (lower-start) run is kept.
  assign w_cur_wins = (r_cur_len > r_best_len);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
    end else if (tap_valid && tap_good) begin
      r_cur_len <= r_cur_len + TAP_W'(1);
      if (r_cur_len == '0) begin
        r_cur_start <= tap_idx;
      end
    end else if ((tap_valid && !tap_good) || close) begin
      if (w_cur_wins) begin
        r_best_start <= r_cur_start;
        r_best_len   <= r_cur_len;
      end
      r_cur_len <= '0;
    end
  end

  always_comb begin
    best_start = w_cur_wins ? r_cur_start : r_best_start;
    best_len   = w_cur_wins ? r_cur_len : r_best_len;
    center     = best_start + (best_len >> 1);
  end

endmodule

// File: rtl/idelay_tap_calibrator.sv
// Calibration sequencer for the cascaded IDELAY wrapper: sweeps every tap, grades it
// from SAMPLE_OK, then steps back to the centre of the longest good window.
module idelay_tap_calibrator
  import idelay_cal_pkg::*;
#(
  parameter int unsigned NUM_TAPS        = 8,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned SAMPLES_PER_TAP = 4,
  parameter int unsigned MIN_WINDOW      = 2,
  parameter int unsigned TAP_W           = tap_width(NUM_TAPS)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SAMPLE_OK,
  output logic             DLY_RST,
  output logic             DLY_CE,
  output logic             DLY_INC,
  output logic [TAP_W-1:0] TAP,
  output logic [TAP_W-1:0] CENTER_TAP,
  output logic [TAP_W-1:0] WINDOW_LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  cal_state_t              r_state;
  cal_state_t              w_next;
  logic [SETTLE_CNT_W-1:0] r_settle_cnt;
  logic [SAMPLE_CNT_W-1:0] r_sample_cnt;
  logic                    r_good;
  logic [TAP_W-1:0]        r_tap;
  logic [TAP_W-1:0]        r_center;
  logic [TAP_W-1:0]        r_win_len;

  logic                    w_start_acc;
  logic                    w_settle_done;
  logic                    w_sample_last;
  logic                    w_good_acc;
  logic                    w_tap_last;
  logic                    w_short_window;
  logic [TAP_W-1:0]        w_best_start;
  logic [TAP_W-1:0]        w_best_len;
  logic [TAP_W-1:0]        w_center;

  assign w_start_acc   = START && ((r_state == IDLE) || (r_state == DONE_S) || (r_state == FAIL_S));
  assign w_settle_done = (r_settle_cnt == SETTLE_CNT_W'(SETTLE_CYCLES - 1));
  assign w_sample_last = (r_state == SAMPLE) && (r_sample_cnt == SAMPLE_CNT_W'(SAMPLES_PER_TAP - 1));
  assign w_good_acc    = SAMPLE_OK && ((r_sample_cnt == '0) || r_good);
  assign w_tap_last    = (r_tap == TAP_W'(NUM_TAPS - 1));
  assign w_short_window = (32'(w_best_len) < MIN_WINDOW);

  idelay_window_tracker #(
    .TAP_W(TAP_W)
  ) u_tracker (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (w_start_acc),
    .tap_valid (w_sample_last),
    .tap_good  (w_good_acc),
    .tap_idx   (r_tap),
    .close     (r_state == EVAL),
    .best_start(w_best_start),
    .best_len  (w_best_len),
    .center    (w_center)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE_S, FAIL_S: if (START) w_next = RST_DLY;
      RST_DLY:              w_next = SETTLE;
      SETTLE:               if (w_settle_done) w_next = SAMPLE;
      SAMPLE: begin
        if (w_sample_last) w_next = w_tap_last ? EVAL : STEP;
      end
      STEP:                 w_next = SETTLE;
      EVAL: begin
        if (w_short_window)       w_next = FAIL_RST;
        else if (w_center == r_tap) w_next = DONE_S;
        else                      w_next = MOVE;
      end
      MOVE:                 w_next = MOVE_SETTLE;
      MOVE_SETTLE: begin
        if (w_settle_done) w_next = (r_tap == r_center) ? DONE_S : MOVE;
      end
      FAIL_RST:             w_next = FAIL_S;
      default:              w_next = IDLE;
    endcase
  end

  always_comb begin
    DLY_RST = 1'b0;
    DLY_CE  = 1'b0;
    DLY_INC = 1'b0;
    BUSY    = 1'b1;
    DONE    = 1'b0;
    ERR     = 1'b0;
    case (r_state)
      RST_DLY, FAIL_RST: DLY_RST = 1'b1;
      STEP: begin
        DLY_CE  = 1'b1;
        DLY_INC = 1'b1;
      end
      MOVE:   DLY_CE = 1'b1;
      IDLE:   BUSY   = 1'b0;
      DONE_S: begin
        BUSY = 1'b0;
        DONE = 1'b1;
      end
      FAIL_S: begin
        BUSY = 1'b0;
        ERR  = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters free-run only inside their own phase and park at zero elsewhere,
  // so each visit to SETTLE/MOVE_SETTLE/SAMPLE starts from a clean count.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
      r_good       <= 1'b0;
    end else begin
      if ((r_state == SETTLE) || (r_state == MOVE_SETTLE)) begin
        r_settle_cnt <= w_settle_done ? '0 : r_settle_cnt + SETTLE_CNT_W'(1);
      end else begin
        r_settle_cnt <= '0;
      end
      if (r_state == SAMPLE) begin
        r_sample_cnt <= w_sample_last ? '0 : r_sample_cnt + SAMPLE_CNT_W'(1);
        r_good       <= w_good_acc;
      end else begin
        r_sample_cnt <= '0;
        r_good       <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tap     <= '0;
      r_center  <= '0;
      r_win_len <= '0;
    end else begin
      case (r_state)
        RST_DLY, FAIL_RST: r_tap <= '0;
        STEP:              r_tap <= r_tap + TAP_W'(1);
        MOVE:              r_tap <= r_tap - TAP_W'(1);
        EVAL: begin
          r_center  <= w_center;
          r_win_len <= w_best_len;
        end
        default: ;
      endcase
    end
  end

  assign TAP        = r_tap;
  assign CENTER_TAP = r_center;
  assign WINDOW_LEN = r_win_len;

endmodule
